nv_nvdla_sdp_wdma_wr_arb: RTL

Shares one DMA write-request port (toward the mcif/cvif selector) between two write requesters: SDP WDMA and a secondary SDP-side writer. Arbitration is packet-locked: a granted requester keeps the port from its command packet through its last data packet. An in-order ack-owner FIFO routes each wr_rsp_complete pulse back to the requester that asked for the ack.

---
 rtl/nv_nvdla_sdp_wdma_wr_arb.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/nv_nvdla_sdp_wdma_wr_arb.sv
// rtl/nv_nvdla_sdp_wdma_wr_arb.sv - packet-locked two-requester DMA write arbiter with in-order ack routing
// Optional stall counters compiled in with SDP_WDMA_ARB_PERF_EN.
module nv_nvdla_sdp_wdma_wr_arb #(
  parameter int ACK_DEPTH = 8,
  parameter int ACK_AW    = 3
) (
  input  logic         nvdla_core_clk,
  input  logic         nvdla_core_rstn,
  input  logic         r0_wr_req_valid,
  output logic         r0_wr_req_ready,
  input  logic [514:0] r0_wr_req_pd,
  input  logic         r1_wr_req_valid,
  output logic         r1_wr_req_ready,
  input  logic [514:0] r1_wr_req_pd,
  output logic         dma_wr_req_valid,
  input  logic         dma_wr_req_ready,
  output logic [514:0] dma_wr_req_pd,
  input  logic         dma_wr_rsp_complete,
  output logic         r0_wr_rsp_complete,
  output logic         r1_wr_rsp_complete,
  input  logic         perf_clr,
  output logic         arb_busy,
  output logic         arb_err,
  output logic [31:0]  r0_stall_cnt,
  output logic [31:0]  r1_stall_cnt
);

  typedef enum logic {ST_IDLE, ST_DATA} state_t;

  state_t                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  rr_ptr_q, rr_ptr_d;
  logic [13:0]           beat_cnt_q, beat_cnt_d;
  logic                  err_q, err_d;
  logic [ACK_DEPTH-1:0]  ack_id_q, ack_id_d;
  logic [ACK_AW-1:0]     ack_wr_q, ack_wr_d;
  logic [ACK_AW-1:0]     ack_rd_q, ack_rd_d;
  logic [ACK_AW:0]       ack_cnt_q, ack_cnt_d;
  logic                  r0_rsp_q, r0_rsp_d;
  logic                  r1_rsp_q, r1_rsp_d;

  logic         ack_full, ack_empty;
  logic         elig0, elig1;
  logic         sel, sel_valid, fwd, accept;
  logic [514:0] sel_pd;
  logic         ack_push, ack_pop;

  assign ack_full  = (ack_cnt_q == (ACK_AW+1)'(ACK_DEPTH));
  assign ack_empty = (ack_cnt_q == '0);

  // A command that needs an ack slot waits while the FIFO is full.
  assign elig0 = r0_wr_req_valid & ~r0_wr_req_pd[514] & ~(r0_wr_req_pd[77] & ack_full);
  assign elig1 = r1_wr_req_valid & ~r1_wr_req_pd[514] & ~(r1_wr_req_pd[77] & ack_full);

  always_comb begin
    sel = grant_q;
    if (state_q == ST_IDLE) begin
      if (elig0 & elig1) sel = rr_ptr_q;
      else               sel = elig1;
    end
  end

  assign sel_valid = sel ? r1_wr_req_valid : r0_wr_req_valid;
  assign sel_pd    = sel ? r1_wr_req_pd    : r0_wr_req_pd;
  assign fwd       = (state_q == ST_IDLE) ? (elig0 | elig1) : (sel_valid & sel_pd[514]);
  assign accept    = fwd & dma_wr_req_ready;

  assign dma_wr_req_valid = fwd;
  assign dma_wr_req_pd    = sel_pd;
  assign r0_wr_req_ready  = fwd & ~sel & dma_wr_req_ready;
  assign r1_wr_req_ready  = fwd &  sel & dma_wr_req_ready;

  assign ack_push = accept & (state_q == ST_IDLE) & sel_pd[77];
  assign ack_pop  = dma_wr_rsp_complete & ~ack_empty;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    if (state_q == ST_IDLE) begin
      if ((r0_wr_req_valid & r0_wr_req_pd[514]) | (r1_wr_req_valid & r1_wr_req_pd[514]))
        err_d = 1'b1;
      if (accept) begin
        state_d    = ST_DATA;
        grant_d    = sel;
        rr_ptr_d   = ~sel;
        beat_cnt_d = {2'b00, sel_pd[76:65]} + 14'd1;
      end
    end else begin
      if (sel_valid & ~sel_pd[514])
        err_d = 1'b1;
      if (accept) begin
        beat_cnt_d = beat_cnt_q - 14'd1;
        if (beat_cnt_q == 14'd1) state_d = ST_IDLE;
      end
    end
    if (dma_wr_rsp_complete & ack_empty)
      err_d = 1'b1;
  end

  always_comb begin
    ack_id_d  = ack_id_q;
    ack_wr_d  = ack_wr_q;
    ack_rd_d  = ack_rd_q;
    ack_cnt_d = ack_cnt_q;
    if (ack_push) begin
      ack_id_d[ack_wr_q] = sel;
      ack_wr_d           = ack_wr_q + 1'b1;
    end
    if (ack_pop)
      ack_rd_d = ack_rd_q + 1'b1;
    case ({ack_push, ack_pop})
      2'b10:   ack_cnt_d = ack_cnt_q + 1'b1;
      2'b01:   ack_cnt_d = ack_cnt_q - 1'b1;
      default: ack_cnt_d = ack_cnt_q;
    endcase
    r0_rsp_d = ack_pop & ~ack_id_q[ack_rd_q];
    r1_rsp_d = ack_pop &  ack_id_q[ack_rd_q];
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b0;
      rr_ptr_q   <= 1'b0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      ack_id_q   <= '0;
      ack_wr_q   <= '0;
      ack_rd_q   <= '0;
      ack_cnt_q  <= '0;
      r0_rsp_q   <= 1'b0;
      r1_rsp_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      ack_id_q   <= ack_id_d;
      ack_wr_q   <= ack_wr_d;
      ack_rd_q   <= ack_rd_d;
      ack_cnt_q  <= ack_cnt_d;
      r0_rsp_q   <= r0_rsp_d;
      r1_rsp_q   <= r1_rsp_d;
    end
  end

  assign r0_wr_rsp_complete = r0_rsp_q;
  assign r1_wr_rsp_complete = r1_rsp_q;
  assign arb_busy           = (state_q == ST_DATA) | ~ack_empty;
  assign arb_err            = err_q;

`ifdef SDP_WDMA_ARB_PERF_EN
  logic [31:0] r0_stall_q, r0_stall_d;
  logic [31:0] r1_stall_q, r1_stall_d;

  // Saturating counters; clear takes priority over a same-cycle stall.
  always_comb begin
    r0_stall_d = r0_stall_q;
    r1_stall_d = r1_stall_q;
    if (perf_clr) begin
      r0_stall_d = '0;
      r1_stall_d = '0;
    end else begin
      if (r0_wr_req_valid & ~r0_wr_req_ready & ~&r0_stall_q) r0_stall_d = r0_stall_q + 32'd1;
      if (r1_wr_req_valid & ~r1_wr_req_ready & ~&r1_stall_q) r1_stall_d = r1_stall_q + 32'd1;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r0_stall_q <= '0;
      r1_stall_q <= '0;
    end else begin
      r0_stall_q <= r0_stall_d;
      r1_stall_q <= r1_stall_d;
    end
  end

  assign r0_stall_cnt = r0_stall_q;
  assign r1_stall_cnt = r1_stall_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign r0_stall_cnt    = '0;
  assign r1_stall_cnt    = '0;
`endif

endmodule
